// File: rtl/motion_estimator_core.sv
// Full-search block-matching motion estimator. A 16x16 reference block is
// compared against every displacement dx, dy in -8..+7 of a 32x32 search
// window. Two horizontally adjacent candidates (dx on lane 1, dx+1 on lane 2)
// are accumulated in parallel. Both memories return data one cycle after the
// address is presented, so each candidate pair takes 256 issue cycles, one
// drain cycle and one compare cycle.
module motion_estimator_core #(
  parameter int BLK_DIM  = 16,
  parameter int SRCH_DIM = 32,
  parameter int SAD_W    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] R,
  input  logic [7:0] S1,
  input  logic [7:0] S2,
  output logic [7:0] AddressR,
  output logic [9:0] AddressS1,
  output logic [9:0] AddressS2,
  output logic [7:0] bestDistance,
  output logic [3:0] motionX,
  output logic [3:0] motionY,
  output logic       completed
);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, CMP, DONE} state_t;

  state_t           state_q, state_d;
  logic [7:0]       p_q, p_d;
  logic [3:0]       dx_q, dx_d;
  logic [3:0]       dy_q, dy_d;
  logic [SAD_W-1:0] sad1_q, sad1_d;
  logic [SAD_W-1:0] sad2_q, sad2_d;
  logic [SAD_W-1:0] best_q, best_d;
  logic [7:0]       best_dist_q, best_dist_d;
  logic [3:0]       mx_q, mx_d;
  logic [3:0]       my_q, my_d;
  logic             completed_q, completed_d;
  logic [7:0]       addr_r_q, addr_r_d;
  logic [9:0]       addr_s1_q, addr_s1_d;
  logic [9:0]       addr_s2_q, addr_s2_d;

  logic [7:0]       diff1, diff2;
  logic [4:0]       row, col;
  logic [9:0]       s1_addr;

  // Next-state, accumulation, best-match update and next address computation.
  // Addresses are registered from the next-cycle counters so the outputs show
  // pixel p during the RUN cycle that holds p, and simply hold outside RUN.
  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    sad1_d      = sad1_q;
    sad2_d      = sad2_q;
    best_d      = best_q;
    best_dist_d = best_dist_q;
    mx_d        = mx_q;
    my_d        = my_q;
    completed_d = completed_q;
    addr_r_d    = addr_r_q;
    addr_s1_d   = addr_s1_q;
    addr_s2_d   = addr_s2_q;
    row         = '0;
    col         = '0;
    s1_addr     = '0;

    diff1 = (R >= S1) ? (R - S1) : (S1 - R);
    diff2 = (R >= S2) ? (R - S2) : (S2 - R);

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = RUN;
          best_d      = '1;
          dy_d        = 4'h8;
          dx_d        = 4'h8;
          p_d         = 8'd0;
          sad1_d      = '0;
          sad2_d      = '0;
          completed_d = 1'b0;
        end
      end
      RUN: begin
        // The first issue cycle of a pair has no returned data yet.
        if (p_q != 8'd0) begin
          sad1_d = sad1_q + SAD_W'(diff1);
          sad2_d = sad2_q + SAD_W'(diff2);
        end
        p_d = p_q + 8'd1;
        if (p_q == 8'(BLK_DIM * BLK_DIM - 1)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        sad1_d  = sad1_q + SAD_W'(diff1);
        sad2_d  = sad2_q + SAD_W'(diff2);
        state_d = CMP;
      end
      CMP: begin
        // Strict less-than keeps the earliest candidate on ties; lane 1 is
        // earlier in scan order than lane 2.
        if (sad1_q < best_d) begin
          best_d = sad1_q;
          mx_d   = dx_q;
          my_d   = dy_q;
        end
        if (sad2_q < best_d) begin
          best_d = sad2_q;
          mx_d   = dx_q + 4'd1;
          my_d   = dy_q;
        end
        best_dist_d = (best_d > SAD_W'(255)) ? 8'hFF : best_d[7:0];
        sad1_d      = '0;
        sad2_d      = '0;
        if (dx_q == 4'd6) begin
          dx_d = 4'h8;
          dy_d = dy_q + 4'd1;
        end else begin
          dx_d = dx_q + 4'd2;
        end
        if (dy_q == 4'd7 && dx_q == 4'd6) begin
          state_d     = DONE;
          completed_d = 1'b1;
        end else begin
          state_d = RUN;
          p_d     = 8'd0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Offset-binary view of dx/dy gives the 8+d term without an adder.
    if (state_d == RUN) begin
      row       = {1'b0, ~dy_d[3], dy_d[2:0]} + {1'b0, p_d[7:4]};
      col       = {1'b0, ~dx_d[3], dx_d[2:0]} + {1'b0, p_d[3:0]};
      s1_addr   = 10'(row) * 10'(SRCH_DIM) + 10'(col);
      addr_r_d  = p_d;
      addr_s1_d = s1_addr;
      addr_s2_d = s1_addr + 10'd1;
    end
  end

  // State and datapath registers; reset aborts any search in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      p_q         <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      sad1_q      <= '0;
      sad2_q      <= '0;
      best_q      <= '0;
      best_dist_q <= '0;
      mx_q        <= '0;
      my_q        <= '0;
      completed_q <= 1'b0;
      addr_r_q    <= '0;
      addr_s1_q   <= '0;
      addr_s2_q   <= '0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      sad1_q      <= sad1_d;
      sad2_q      <= sad2_d;
      best_q      <= best_d;
      best_dist_q <= best_dist_d;
      mx_q        <= mx_d;
      my_q        <= my_d;
      completed_q <= completed_d;
      addr_r_q    <= addr_r_d;
      addr_s1_q   <= addr_s1_d;
      addr_s2_q   <= addr_s2_d;
    end
  end

  assign AddressR     = addr_r_q;
  assign AddressS1    = addr_s1_q;
  assign AddressS2    = addr_s2_q;
  assign bestDistance = best_dist_q;
  assign motionX      = mx_q;
  assign motionY      = my_q;
  assign completed    = completed_q;

endmodule
